// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad column scanner with row synchronizer, press/release debounce and key decode.
// Build option: define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_SAMPLES samples while a key is held.
module keypad_scan #(
   parameter int SCAN_TICKS     = 100000,
   parameter int DEBOUNCE_CNT   = 8,
   parameter int REPEAT_SAMPLES = 250
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);
   localparam int TW = $clog2(SCAN_TICKS);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CNT - 1);

   generate
      if (SCAN_TICKS < 4) begin : g_bad_scan_ticks
         $error("keypad_scan: SCAN_TICKS must be >= 4");
      end
      if (DEBOUNCE_CNT < 1) begin : g_bad_debounce_cnt
         $error("keypad_scan: DEBOUNCE_CNT must be >= 1");
      end
      if (REPEAT_SAMPLES < 1) begin : g_bad_repeat_samples
         $error("keypad_scan: REPEAT_SAMPLES must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   logic [3:0]    sync_q, rs_q;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [3:0]    col_q;
   state_t        state_q;
   logic [1:0]    cand_row_q;
   logic [CW-1:0] match_q, rel_q;
   logic [3:0]    key_code_q;
   logic          key_valid_q, key_held_q;
`ifdef KEYPAD_REPEAT_EN
   localparam int RW = $clog2(REPEAT_SAMPLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SAMPLES - 1);
   logic [RW-1:0] rep_q;
`endif

   logic       single, idle, sample, cand_hit;
   logic [1:0] hit_row;

   function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
      logic [3:0] k;
      k = 4'h0;
      case ({c, r})
         4'h0: k = 4'h1;
         4'h1: k = 4'h4;
         4'h2: k = 4'h7;
         4'h3: k = 4'h0;
         4'h4: k = 4'h2;
         4'h5: k = 4'h5;
         4'h6: k = 4'h8;
         4'h7: k = 4'hF;
         4'h8: k = 4'h3;
         4'h9: k = 4'h6;
         4'hA: k = 4'h9;
         4'hB: k = 4'hE;
         4'hC: k = 4'hA;
         4'hD: k = 4'hB;
         4'hE: k = 4'hC;
         4'hF: k = 4'hD;
         default: k = 4'h0;
      endcase
      return k;
   endfunction

   // A sample counts as a key only when exactly one row is pulled low.
   always_comb begin
      single  = 1'b1;
      hit_row = 2'd0;
      case (rs_q)
         4'b1110: hit_row = 2'd0;
         4'b1101: hit_row = 2'd1;
         4'b1011: hit_row = 2'd2;
         4'b0111: hit_row = 2'd3;
         default: single = 1'b0;
      endcase
   end

   assign idle      = (rs_q == 4'b1111);
   assign sample    = (timer_q == TICK_LAST);
   assign cand_hit  = single && (hit_row == cand_row_q);
   assign timer_d   = sample ? '0 : timer_q + 1'b1;
   assign col_idx_d = col_idx_q + 2'd1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q      <= 4'hF;
         rs_q        <= 4'hF;
         timer_q     <= '0;
         col_idx_q   <= 2'd0;
         col_q       <= 4'b1110;
         state_q     <= SCAN;
         cand_row_q  <= 2'd0;
         match_q     <= '0;
         rel_q       <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         sync_q      <= row;
         rs_q        <= sync_q;
         timer_q     <= timer_d;
         key_valid_q <= 1'b0;
         if (sample) begin
            case (state_q)
               SCAN: begin
                  if (single) begin
                     cand_row_q <= hit_row;
                     if (DEBOUNCE_CNT == 1) begin
                        key_code_q  <= key_map(col_idx_q, hit_row);
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        rel_q       <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_q       <= '0;
`endif
                        state_q     <= HELD;
                     end else begin
                        match_q <= CW'(1);
                        state_q <= DEBOUNCE;
                     end
                  end else begin
                     col_idx_q <= col_idx_d;
                     col_q     <= ~(4'b0001 << col_idx_d);
                  end
               end
               DEBOUNCE: begin
                  if (cand_hit) begin
                     if (match_q == CNT_LAST) begin
                        key_code_q  <= key_map(col_idx_q, cand_row_q);
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        rel_q       <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_q       <= '0;
`endif
                        state_q     <= HELD;
                     end else begin
                        match_q <= match_q + 1'b1;
                     end
                  end else begin
                     state_q   <= SCAN;
                     col_idx_q <= col_idx_d;
                     col_q     <= ~(4'b0001 << col_idx_d);
                  end
               end
               HELD: begin
                  // Column stays frozen, so another key in this column only resets the release count.
                  if (idle) begin
                     if (rel_q == CNT_LAST) begin
                        key_held_q <= 1'b0;
                        rel_q      <= '0;
                        state_q    <= SCAN;
                        col_idx_q  <= col_idx_d;
                        col_q      <= ~(4'b0001 << col_idx_d);
                     end else begin
                        rel_q <= rel_q + 1'b1;
                     end
                  end else begin
                     rel_q <= '0;
                  end
`ifdef KEYPAD_REPEAT_EN
                  if (cand_hit) begin
                     if (rep_q == REP_LAST) begin
                        key_valid_q <= 1'b1;
                        rep_q       <= '0;
                     end else begin
                        rep_q <= rep_q + 1'b1;
                     end
                  end else begin
                     rep_q <= '0;
                  end
`endif
               end
               default: state_q <= SCAN;
            endcase
         end
      end
   end

   assign col       = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
endmodule
